// File: rtl/cw305_reg_ml.sv
// Byte-wide USB register file for the CW305 ML target: holds the input, weight and bias
// vectors for the core, returns its outputs, and generates the start pulse and done flag.
`timescale 1ns / 1ps
module cw305_reg_ml #(
   parameter int unsigned pADDR_WIDTH   = 21,
   parameter int unsigned pBYTECNT_SIZE = 7,
   parameter int unsigned pINPUTCNT     = 4,
   parameter int unsigned pWEIGHTCNT    = 16,
   parameter int unsigned pBIASCNT      = 16,
   parameter int unsigned pOUTPUTCNT    = 4
) (
   input  logic                                   usb_clk,
   input  logic                                   reset_n,
   input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
   input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
   input  logic [7:0]                             write_data,
   output logic [7:0]                             read_data,
   input  logic                                   reg_read,
   input  logic                                   reg_write,
   input  logic                                   reg_addrvalid,
   output logic [8*pINPUTCNT-1:0]                 O_inputs,
   output logic [8*pWEIGHTCNT-1:0]                O_weights,
   output logic [8*pBIASCNT-1:0]                  O_bias,
   output logic                                   O_start,
   input  logic [8*pOUTPUTCNT-1:0]                I_outputs,
   input  logic                                   I_busy
);

   localparam int unsigned AW = pADDR_WIDTH - pBYTECNT_SIZE;

   localparam logic [AW-1:0] AddrGo      = AW'(0);
   localparam logic [AW-1:0] AddrStatus  = AW'(1);
   localparam logic [AW-1:0] AddrInputs  = AW'(4);
   localparam logic [AW-1:0] AddrWeights = AW'(5);
   localparam logic [AW-1:0] AddrBias    = AW'(6);
   localparam logic [AW-1:0] AddrOutputs = AW'(7);

   logic [8*pINPUTCNT-1:0]  inputs_q,  inputs_d;
   logic [8*pWEIGHTCNT-1:0] weights_q, weights_d;
   logic [8*pBIASCNT-1:0]   bias_q,    bias_d;
   logic [7:0]              read_data_q, read_data_d;
   logic                    start_q, start_d;
   logic                    done_q, done_d;
   logic                    busy_prev_q;
   logic                    wr_en, rd_en;
   logic [7:0]              rd_byte;

   assign wr_en = reg_write && reg_addrvalid;
   assign rd_en = reg_read && reg_addrvalid;

   // Byte lanes are matched against the loop index so out-of-range bytecnt writes nothing.
   always_comb begin
      inputs_d  = inputs_q;
      weights_d = weights_q;
      bias_d    = bias_q;
      for (int k = 0; k < int'(pINPUTCNT); k++) begin
         if (wr_en && reg_address == AddrInputs && reg_bytecnt == pBYTECNT_SIZE'(k)) begin
            inputs_d[8*k +: 8] = write_data;
         end
      end
      for (int k = 0; k < int'(pWEIGHTCNT); k++) begin
         if (wr_en && reg_address == AddrWeights && reg_bytecnt == pBYTECNT_SIZE'(k)) begin
            weights_d[8*k +: 8] = write_data;
         end
      end
      for (int k = 0; k < int'(pBIASCNT); k++) begin
         if (wr_en && reg_address == AddrBias && reg_bytecnt == pBYTECNT_SIZE'(k)) begin
            bias_d[8*k +: 8] = write_data;
         end
      end
   end

   // Reads see pre-write storage, so a simultaneous read returns the old byte.
   always_comb begin
      rd_byte = 8'h00;
      case (reg_address)
         AddrStatus: rd_byte = {6'b0, done_q, I_busy};
         AddrInputs: begin
            for (int k = 0; k < int'(pINPUTCNT); k++) begin
               if (reg_bytecnt == pBYTECNT_SIZE'(k)) rd_byte = inputs_q[8*k +: 8];
            end
         end
         AddrWeights: begin
            for (int k = 0; k < int'(pWEIGHTCNT); k++) begin
               if (reg_bytecnt == pBYTECNT_SIZE'(k)) rd_byte = weights_q[8*k +: 8];
            end
         end
         AddrBias: begin
            for (int k = 0; k < int'(pBIASCNT); k++) begin
               if (reg_bytecnt == pBYTECNT_SIZE'(k)) rd_byte = bias_q[8*k +: 8];
            end
         end
         AddrOutputs: begin
            for (int k = 0; k < int'(pOUTPUTCNT); k++) begin
               if (reg_bytecnt == pBYTECNT_SIZE'(k)) rd_byte = I_outputs[8*k +: 8];
            end
         end
         default: rd_byte = 8'h00;
      endcase
   end

   always_comb begin
      read_data_d = rd_en ? rd_byte : read_data_q;
      start_d     = wr_en && (reg_address == AddrGo) && write_data[0];
      // Clearing on the start pulse takes priority over a coincident busy falling edge.
      if (start_q) begin
         done_d = 1'b0;
      end else if (busy_prev_q && !I_busy) begin
         done_d = 1'b1;
      end else begin
         done_d = done_q;
      end
   end

   always_ff @(posedge usb_clk or negedge reset_n) begin
      if (!reset_n) begin
         inputs_q    <= '0;
         weights_q   <= '0;
         bias_q      <= '0;
         read_data_q <= 8'h00;
         start_q     <= 1'b0;
         done_q      <= 1'b0;
         busy_prev_q <= 1'b0;
      end else begin
         inputs_q    <= inputs_d;
         weights_q   <= weights_d;
         bias_q      <= bias_d;
         read_data_q <= read_data_d;
         start_q     <= start_d;
         done_q      <= done_d;
         busy_prev_q <= I_busy;
      end
   end

   assign O_inputs  = inputs_q;
   assign O_weights = weights_q;
   assign O_bias    = bias_q;
   assign read_data = read_data_q;
   assign O_start   = start_q;

endmodule

// File: tb/tb_cw305_reg_ml.sv
// Directed and randomized checks of cw305_reg_ml against a byte-array register model.
`timescale 1ns / 1ps
module tb_cw305_reg_ml;

   logic         usb_clk = 1'b0;
   logic         reset_n;
   logic [13:0]  reg_address;
   logic [6:0]   reg_bytecnt;
   logic [7:0]   write_data;
   logic [7:0]   read_data;
   logic         reg_read, reg_write, reg_addrvalid;
   logic [31:0]  O_inputs;
   logic [127:0] O_weights;
   logic [127:0] O_bias;
   logic         O_start;
   logic [31:0]  I_outputs;
   logic         I_busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain byte arrays plus start/done bookkeeping.
   logic [7:0] m_in[4];
   logic [7:0] m_w[16];
   logic [7:0] m_b[16];
   logic [7:0] m_rd;
   logic       m_done, m_busy_q, m_start_q;

   always #5 usb_clk = ~usb_clk;

   cw305_reg_ml dut (
      .usb_clk       (usb_clk),
      .reset_n       (reset_n),
      .reg_address   (reg_address),
      .reg_bytecnt   (reg_bytecnt),
      .write_data    (write_data),
      .read_data     (read_data),
      .reg_read      (reg_read),
      .reg_write     (reg_write),
      .reg_addrvalid (reg_addrvalid),
      .O_inputs      (O_inputs),
      .O_weights     (O_weights),
      .O_bias        (O_bias),
      .O_start       (O_start),
      .I_outputs     (I_outputs),
      .I_busy        (I_busy)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] flat_in();
      logic [31:0] v;
      for (int k = 0; k < 4; k++) v[8*k +: 8] = m_in[k];
      return v;
   endfunction

   function automatic logic [127:0] flat16(input logic [7:0] arr[16]);
      logic [127:0] v;
      for (int k = 0; k < 16; k++) v[8*k +: 8] = arr[k];
      return v;
   endfunction

   function automatic logic [7:0] model_read(input logic [13:0] a, input int idx);
      case (a)
         14'd1:   return {6'b0, m_done, I_busy};
         14'd4:   return (idx < 4)  ? m_in[idx] : 8'h00;
         14'd5:   return (idx < 16) ? m_w[idx]  : 8'h00;
         14'd6:   return (idx < 16) ? m_b[idx]  : 8'h00;
         14'd7:   return (idx < 4)  ? I_outputs[8*idx +: 8] : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_write(input logic [13:0] a, input int idx, input logic [7:0] d);
      if (a == 14'd4 && idx < 4)  m_in[idx] = d;
      if (a == 14'd5 && idx < 16) m_w[idx]  = d;
      if (a == 14'd6 && idx < 16) m_b[idx]  = d;
   endtask

   // What one rising edge does to start/done, given what was true just before it.
   task automatic model_edge(input logic go);
      if (m_start_q) m_done = 1'b0;
      else if (m_busy_q && !I_busy) m_done = 1'b1;
      m_busy_q  = I_busy;
      m_start_q = go;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_in[k] = 8'h00;
      for (int k = 0; k < 16; k++) begin
         m_w[k] = 8'h00;
         m_b[k] = 8'h00;
      end
      m_rd = 8'h00; m_done = 1'b0; m_busy_q = 1'b0; m_start_q = 1'b0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".read_data"}, 128'(read_data), 128'(m_rd));
      check({tag, ".O_inputs"}, 128'(O_inputs), 128'(flat_in()));
      check({tag, ".O_weights"}, O_weights, flat16(m_w));
      check({tag, ".O_bias"}, O_bias, flat16(m_b));
      check({tag, ".O_start"}, 128'(O_start), 128'(m_start_q));
   endtask

   // Called at a falling edge; drives one bus cycle and checks at the next falling edge.
   task automatic bus_op(input logic [13:0] a, input int idx, input logic [7:0] d,
                         input logic rd, input logic wr, input logic av, input string tag);
      logic go;
      reg_address = a; reg_bytecnt = 7'(idx); write_data = d;
      reg_read = rd; reg_write = wr; reg_addrvalid = av;
      go = wr && av && (a == 14'd0) && d[0];
      if (rd && av) m_rd = model_read(a, idx);
      model_edge(go);
      if (wr && av) model_write(a, idx, d);
      @(negedge usb_clk);
      reg_read = 1'b0; reg_write = 1'b0; reg_addrvalid = 1'b0;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      model_edge(1'b0);
      @(negedge usb_clk);
      check_all(tag);
   endtask

   initial begin
      logic [7:0] exp_out[4];
      reset_n = 1'b0; reg_address = '0; reg_bytecnt = '0; write_data = '0;
      reg_read = 1'b0; reg_write = 1'b0; reg_addrvalid = 1'b0;
      I_outputs = 32'h0; I_busy = 1'b0;
      model_reset();
      repeat (3) @(negedge usb_clk);
      check_all("por");
      reset_n = 1'b1;
      @(negedge usb_clk);

      // Populate state, then reset in the middle of a write.
      bus_op(14'd5, 3, 8'h3C, 1'b0, 1'b1, 1'b1, "pre_w");
      bus_op(14'd5, 3, 8'h00, 1'b1, 1'b0, 1'b1, "pre_r");
      check("pre_r_val", 128'(read_data), 128'h3C);
      reg_address = 14'd4; reg_bytecnt = 7'd0; write_data = 8'h99;
      reg_write = 1'b1; reg_addrvalid = 1'b1;
      reset_n = 1'b0;
      model_reset();
      #1 check_all("rst_async");
      @(negedge usb_clk);
      check_all("rst_hold");
      reg_write = 1'b0; reg_addrvalid = 1'b0;
      reset_n = 1'b1;
      @(negedge usb_clk);
      bus_op(14'd5, 3, 8'h00, 1'b1, 1'b0, 1'b1, "rst_rd_w3");

      // Inputs register
      for (int k = 0; k < 4; k++) bus_op(14'd4, k, 8'(k + 1), 1'b0, 1'b1, 1'b1, "in_w");
      check("in_vec", 128'(O_inputs), 128'h04030201);
      bus_op(14'd4, 2, 8'h00, 1'b1, 1'b0, 1'b1, "in_r2");
      check("in_r2_val", 128'(read_data), 128'h03);

      // Weight/bias range limits
      bus_op(14'd5, 15, 8'hAA, 1'b0, 1'b1, 1'b1, "w15");
      bus_op(14'd6, 0, 8'h55, 1'b0, 1'b1, 1'b1, "b0");
      check("w15_val", 128'(O_weights[127:120]), 128'hAA);
      check("b0_val", 128'(O_bias[7:0]), 128'h55);
      bus_op(14'd5, 16, 8'hFF, 1'b0, 1'b1, 1'b1, "w16_ign");
      bus_op(14'd5, 16, 8'h00, 1'b1, 1'b0, 1'b1, "w16_rd");
      check("w16_rd_val", 128'(read_data), 128'h00);

      // Outputs: read-only, sourced live from I_outputs
      I_outputs = 32'hDEADBEEF;
      exp_out[0] = 8'hEF; exp_out[1] = 8'hBE; exp_out[2] = 8'hAD; exp_out[3] = 8'hDE;
      for (int k = 0; k < 4; k++) begin
         bus_op(14'd7, k, 8'h00, 1'b1, 1'b0, 1'b1, "out_rd");
         check("out_rd_val", 128'(read_data), 128'(exp_out[k]));
      end
      bus_op(14'd7, 0, 8'h12, 1'b0, 1'b1, 1'b1, "out_w_ign");

      // GO / STATUS
      bus_op(14'd0, 0, 8'h01, 1'b0, 1'b1, 1'b1, "go1");
      check("go1_start_hi", 128'(O_start), 128'h1);
      idle("go1_end");
      check("go1_start_lo", 128'(O_start), 128'h0);
      bus_op(14'd0, 0, 8'h00, 1'b0, 1'b1, 1'b1, "go0_nop");
      I_busy = 1'b1;
      idle("busy_hi");
      bus_op(14'd1, 0, 8'h00, 1'b1, 1'b0, 1'b1, "stat_busy");
      check("stat_busy_val", 128'(read_data), 128'h01);
      I_busy = 1'b0;
      idle("busy_fall");
      bus_op(14'd1, 0, 8'h00, 1'b1, 1'b0, 1'b1, "stat_done");
      check("stat_done_val", 128'(read_data), 128'h02);
      bus_op(14'd0, 0, 8'h01, 1'b0, 1'b1, 1'b1, "go2");
      idle("go2_end");
      bus_op(14'd1, 0, 8'h00, 1'b1, 1'b0, 1'b1, "stat_clr");
      check("stat_clr_val", 128'(read_data), 128'h00);

      // Busy falls in the same cycle as the start pulse: clear must win.
      I_busy = 1'b1;
      idle("b2_hi");
      I_busy = 1'b0;
      idle("b2_fall");
      I_busy = 1'b1;
      idle("b3_hi");
      bus_op(14'd0, 0, 8'h01, 1'b0, 1'b1, 1'b1, "go3");
      I_busy = 1'b0;
      idle("go3_coincide");
      bus_op(14'd1, 0, 8'h00, 1'b1, 1'b0, 1'b1, "stat_tie");
      check("stat_tie_val", 128'(read_data), 128'h00);

      // Unmapped read and simultaneous read+write
      bus_op(14'd3, 0, 8'h00, 1'b1, 1'b0, 1'b1, "unmapped");
      check("unmapped_val", 128'(read_data), 128'h00);
      bus_op(14'd4, 0, 8'h77, 1'b1, 1'b1, 1'b1, "rw_same");
      check("rw_old", 128'(read_data), 128'h01);
      check("rw_new", 128'(O_inputs[7:0]), 128'h77);

      // Randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         logic [13:0] a;
         I_busy    = 1'($urandom_range(0, 1));
         I_outputs = $urandom;
         a = 14'($urandom_range(0, 8));
         bus_op(a, int'($urandom_range(0, 19)), 8'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 7) != 0, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
